// File: rtl/jump_unit_pipelined_if.sv
// Command/result handshake bundle for jump_unit_pipelined.
// master = sequencer side, slave = jump unit.
interface jump_unit_pipelined_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       cmd;
  logic [WIDTH-1:0]  jump_arg_1;
  logic [WIDTH-1:0]  jump_arg_2;
  logic [ADDR_W-1:0] jump_dest;
  logic [ADDR_W-1:0] pc;
  logic              out_valid;
  logic              out_ready;
  logic              is_jump;
  logic              should_jump;
  logic [ADDR_W-1:0] jump_target;

  modport master (
    output in_valid, cmd, jump_arg_1, jump_arg_2,
    output jump_dest, pc, out_ready,
    input  in_ready, out_valid, is_jump,
    input  should_jump, jump_target
  );

  modport slave (
    input  in_valid, cmd, jump_arg_1, jump_arg_2,
    input  jump_dest, pc, out_ready,
    output in_ready, out_valid, is_jump,
    output should_jump, jump_target
  );
endinterface

// File: rtl/jump_unit_pipelined.sv
// Registered jump decision with CALL/RET return stack.
// JUMP_UNIT_STATS_EN enables taken/not-taken counters.
module jump_unit_pipelined #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  jump_unit_pipelined_if.slave bus,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic        stack_overflow,
  output logic        stack_underflow,
  output logic [31:0] taken_count,
  output logic [31:0] not_taken_count
);
  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam logic [LW-1:0] FULL = LW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    T_ALW, T_MASK, T_CMP, T_ZERO,
    T_BIT, T_CALL, T_RET, T_RSV
  } jtype_e;

  logic [31:0]       cmd;
  logic [WIDTH-1:0]  a1;
  logic [WIDTH-1:0]  a2;
  jtype_e            jt;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic              is_jump_q, is_jump_d;
  logic              should_jump_q, should_jump_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stk_d [STACK_DEPTH];

  assign cmd    = bus.cmd;
  assign a1     = bus.jump_arg_1;
  assign a2     = bus.jump_arg_2;
  assign jt     = jtype_e'(cmd[21:19]);
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready    = !out_valid_q || bus.out_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.is_jump     = is_jump_q;
  assign bus.should_jump = should_jump_q;
  assign bus.jump_target = target_q;
  assign stack_level     = level_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

  logic unused_cmd;
  assign unused_cmd = ^cmd[18:6];

  logic [IW-1:0]     push_idx;
  logic [IW-1:0]     top_idx;
  assign push_idx = IW'(level_q);
  assign top_idx  = IW'(level_q - 1'b1);

  logic [WIDTH-1:0]  rep, comb_m, match, shifted;
  logic              lt, eq, gt, zlt, zeq, zgt;
  logic              dec_is_jump, dec_take;
  logic [ADDR_W-1:0] dec_target;
  logic              do_push, do_pop, ovf_set, unf_set;

  always_comb begin
    rep     = {WIDTH{cmd[0]}};
    comb_m  = (~a2 & rep) | (a2 & a1);
    match   = ~(comb_m ^ rep);
    lt      = cmd[0] ? ($signed(a1) < $signed(a2))
                     : (a1 < a2);
    eq      = a1 == a2;
    gt      = !lt && !eq;
    zlt     = a1[WIDTH-1];
    zeq     = a1 == '0;
    zgt     = !zlt && !zeq;
    // out-of-range bit indices shift in zeros
    shifted = a1 >> cmd[5:1];
    dec_is_jump = cmd[31:22] == 10'b0010000000;
    dec_take    = 1'b0;
    dec_target  = bus.jump_dest;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    if (dec_is_jump) begin
      unique case (1'b1)
        (jt == T_ALW):  dec_take = 1'b1;
        (jt == T_MASK): dec_take = cmd[1] ? |match
                                          : &match;
        (jt == T_CMP):  dec_take = (lt && cmd[3]) ||
                                   (eq && cmd[2]) ||
                                   (gt && cmd[1]);
        (jt == T_ZERO): dec_take = (zlt && cmd[2]) ||
                                   (zeq && cmd[1]) ||
                                   (zgt && cmd[0]);
        (jt == T_BIT):  dec_take = shifted[0] == cmd[0];
        (jt == T_CALL): begin
          dec_take = 1'b1;
          if (level_q == FULL) ovf_set = 1'b1;
          else                 do_push = 1'b1;
        end
        (jt == T_RET): begin
          if (level_q == '0) begin
            unf_set = 1'b1;
          end else begin
            do_pop     = 1'b1;
            dec_take   = 1'b1;
            dec_target = stk_q[top_idx];
          end
        end
        default: dec_take = 1'b0;
      endcase
    end
    if (!dec_take) dec_target = '0;
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    is_jump_d     = is_jump_q;
    should_jump_d = should_jump_q;
    target_d      = target_q;
    level_d       = level_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    stk_d         = stk_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      is_jump_d     = dec_is_jump;
      should_jump_d = dec_take;
      target_d      = dec_target;
      ovf_d         = ovf_q | ovf_set;
      unf_d         = unf_q | unf_set;
      if (do_push) begin
        stk_d[push_idx] = bus.pc + 1'b1;
        level_d         = level_q + 1'b1;
      end
      if (do_pop) level_d = level_q - 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      is_jump_q     <= 1'b0;
      should_jump_q <= 1'b0;
      target_q      <= '0;
      level_q       <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      is_jump_q     <= is_jump_d;
      should_jump_q <= should_jump_d;
      target_q      <= target_d;
      level_q       <= level_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      stk_q         <= stk_d;
    end
  end

`ifdef JUMP_UNIT_STATS_EN
  logic [31:0] taken_q, taken_d;
  logic [31:0] nt_q, nt_d;
  logic        deliver;

  assign deliver = out_valid_q && bus.out_ready
                && is_jump_q;

  always_comb begin
    taken_d = taken_q;
    nt_d    = nt_q;
    if (deliver) begin
      if (should_jump_q) begin
        if (taken_q != '1) taken_d = taken_q + 1'b1;
      end else begin
        if (nt_q != '1) nt_d = nt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q <= '0;
      nt_q    <= '0;
    end else begin
      taken_q <= taken_d;
      nt_q    <= nt_d;
    end
  end

  assign taken_count     = taken_q;
  assign not_taken_count = nt_q;
`else
  assign taken_count     = '0;
  assign not_taken_count = '0;
`endif
endmodule
